// File: rtl/cpu_pkg.sv
// Shared CPU constants and the program loader state encoding.
// LOADER_CHECKSUM_EN adds the CHECK state for the trailing check byte.
package cpu_pkg;

    localparam int RAM_BYTES  = 16;
    localparam int RAM_ADDR_W = 4;

    typedef enum logic [2:0] {
        LD_IDLE     = 3'd0,
        LD_ARMED    = 3'd1,
        LD_WRITE    = 3'd2,
        LD_WAIT_LOW = 3'd3,
        LD_FINISH   = 3'd4
`ifdef LOADER_CHECKSUM_EN
        ,
        LD_CHECK    = 3'd5
`endif
    } loader_state_t;

endpackage

// File: rtl/program_loader_edge_sync.sv
// Two-flop synchroniser for an asynchronous pad input,
// plus a rising-edge detect on the synchronised level.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    // Synchroniser chain and edge-detect history flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s3;

endmodule

// File: rtl/program_loader.sv
// Feeds strobed program bytes into the CPU program RAM and holds the CPU meanwhile.
// LOADER_CHECKSUM_EN adds a trailing check byte and the csum_err output.
module program_loader #(
    parameter int RAM_BYTES = cpu_pkg::RAM_BYTES,
    parameter int ADDR_W    = cpu_pkg::RAM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic              load_end,
    input  logic              wr_strobe,
    input  logic [7:0]        data_in,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_data,
    output logic              ram_we,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   byte_count
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic              csum_err
`endif
);

    import cpu_pkg::*;

    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(RAM_BYTES - 1);

    loader_state_t state;

    logic stb_lvl;
    logic stb_rise;
    logic req_lvl;
    logic req_rise;
    logic end_lvl;
    logic end_rise;
    logic unused_sync;

    edge_sync u_stb_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (wr_strobe),
        .level (stb_lvl),
        .rise  (stb_rise)
    );

    edge_sync u_req_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (load_req),
        .level (req_lvl),
        .rise  (req_rise)
    );

    edge_sync u_end_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (load_end),
        .level (end_lvl),
        .rise  (end_rise)
    );

    // Session start is edge-triggered, early end is level-triggered.
    assign unused_sync = req_lvl ^ end_rise;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum;
    logic [7:0] csum_next;

    assign csum_next = csum + data_in;
`endif

    // Load session sequencer with registered RAM and CPU-control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LD_IDLE;
            ram_addr   <= '0;
            ram_data   <= 8'h00;
            ram_we     <= 1'b0;
            cpu_hold   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            byte_count <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum       <= 8'h00;
            csum_err   <= 1'b0;
`endif
        end else begin
            ram_we <= 1'b0;
            unique case (state)
                LD_IDLE: begin
                    if (req_rise) begin
                        state      <= LD_ARMED;
                        ram_addr   <= '0;
                        byte_count <= '0;
                        done       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        csum       <= 8'h00;
`endif
                    end
                end
                LD_ARMED: begin
                    busy     <= 1'b1;
                    cpu_hold <= 1'b1;
                    if (end_lvl) begin
                        state    <= LD_FINISH;
`ifdef LOADER_CHECKSUM_EN
                        csum_err <= 1'b1;
`endif
                    end else if (stb_rise) begin
                        ram_data <= data_in;
                        ram_we   <= 1'b1;
                        state    <= LD_WRITE;
                    end
                end
                LD_WRITE: begin
                    byte_count <= byte_count + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    csum       <= csum + ram_data;
`endif
                    if (byte_count == LAST_CNT) begin
`ifdef LOADER_CHECKSUM_EN
                        state <= LD_CHECK;
`else
                        state <= LD_FINISH;
`endif
                    end else begin
                        ram_addr <= ram_addr + 1'b1;
                        state    <= LD_WAIT_LOW;
                    end
                end
                LD_WAIT_LOW: begin
                    if (!stb_lvl) begin
                        state <= LD_ARMED;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                LD_CHECK: begin
                    if (end_lvl) begin
                        csum_err <= 1'b1;
                        state    <= LD_FINISH;
                    end else if (stb_rise) begin
                        csum_err <= (csum_next != 8'h00);
                        state    <= LD_FINISH;
                    end
                end
`endif
                LD_FINISH: begin
                    done     <= 1'b1;
                    busy     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                    cpu_hold <= csum_err;
`else
                    cpu_hold <= 1'b0;
`endif
                    state    <= LD_IDLE;
                end
                default: begin
                    state <= LD_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed and randomized bench for program_loader.
// Writes are scored against a per-strobe session model.
module tb_program_loader;

    import cpu_pkg::*;

    localparam int N  = RAM_BYTES;
    localparam int AW = RAM_ADDR_W;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_req;
    logic          load_end;
    logic          wr_strobe;
    logic [7:0]    data_in;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_data;
    logic          ram_we;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic [AW:0]   byte_count;
`ifdef LOADER_CHECKSUM_EN
    logic          csum_err;
`endif

    always #5 clk = ~clk;

    program_loader #(
        .RAM_BYTES (N),
        .ADDR_W    (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_req   (load_req),
        .load_end   (load_end),
        .wr_strobe  (wr_strobe),
        .data_in    (data_in),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .ram_we     (ram_we),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .byte_count (byte_count)
`ifdef LOADER_CHECKSUM_EN
        ,
        .csum_err   (csum_err)
`endif
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor and done-edge recorder
    logic [AW-1:0] got_a[$];
    logic [7:0]    got_d[$];
    logic          prev_done = 1'b0;
    logic          prev_hold = 1'b0;
    bit            done_seen = 0;
    logic          hold_at_rise;
    logic          busy_at_rise;
    logic          prev_hold_at_rise;

    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            got_a.push_back(ram_addr);
            got_d.push_back(ram_data);
        end
        if (done === 1'b1 && prev_done === 1'b0) begin
            hold_at_rise      = cpu_hold;
            busy_at_rise      = busy;
            prev_hold_at_rise = prev_hold;
            done_seen         = 1;
        end
        prev_done = done;
        prev_hold = cpu_hold;
    end

    // Reference model: one call per delivered strobe / session event
    bit            m_active = 0;
    bit            m_check  = 0;
    int            m_idx    = 0;
    logic [7:0]    m_sum    = 8'h00;
    bit            m_cerr   = 0;
    logic [AW-1:0] exp_a[$];
    logic [7:0]    exp_d[$];

    function automatic void m_start();
        if (!m_active) begin
            m_active = 1;
            m_check  = 0;
            m_idx    = 0;
            m_sum    = 8'h00;
        end
    endfunction

    function automatic void m_byte(input logic [7:0] d);
        if (!m_active) return;
        if (m_check) begin
            m_cerr   = (8'(m_sum + d) != 8'h00);
            m_active = 0;
            m_check  = 0;
            return;
        end
        exp_a.push_back(AW'(m_idx));
        exp_d.push_back(d);
        m_sum = m_sum + d;
        m_idx++;
        if (m_idx == N) begin
`ifdef LOADER_CHECKSUM_EN
            m_check = 1;
`else
            m_active = 0;
`endif
        end
    endfunction

    function automatic void m_end();
        if (m_active) begin
            m_active = 0;
            m_check  = 0;
`ifdef LOADER_CHECKSUM_EN
            m_cerr = 1;
`endif
        end
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic req();
        done_seen = 0;
        load_req  = 1'b1;
        cyc(3);
        load_req  = 1'b0;
        cyc(3);
        m_start();
    endtask

    task automatic strobe_byte(input logic [7:0] d, input int hi);
        data_in   = d;
        wr_strobe = 1'b1;
        cyc(hi);
        wr_strobe = 1'b0;
        data_in   = 8'($urandom);
        cyc(4);
        m_byte(d);
    endtask

    task automatic end_only();
        load_end = 1'b1;
        cyc(3);
        load_end = 1'b0;
        cyc(1);
        m_end();
    endtask

    task automatic cmp_writes(input string tag);
        int n;
        chk({tag, " nwrites"}, got_a.size(), exp_a.size());
        n = (got_a.size() < exp_a.size()) ? got_a.size() : exp_a.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, " addr"}, got_a[i], exp_a[i]);
            chk({tag, " data"}, got_d[i], exp_d[i]);
        end
        got_a.delete();
        got_d.delete();
        exp_a.delete();
        exp_d.delete();
    endtask

    task automatic end_session(input string tag);
        int k;
        k = 0;
        while (!done_seen && k < 40) begin
            cyc(1);
            k++;
        end
        chk({tag, " done_edge"}, done_seen, 1);
        if (done_seen) begin
            chk({tag, " busy@done"}, busy_at_rise, 0);
            chk({tag, " hold@done"}, hold_at_rise, m_cerr);
            chk({tag, " hold_before"}, prev_hold_at_rise, 1);
        end
        cyc(2);
        chk({tag, " done"}, done, 1);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " hold"}, cpu_hold, m_cerr);
        chk({tag, " count"}, byte_count, m_idx);
`ifdef LOADER_CHECKSUM_EN
        chk({tag, " csum_err"}, csum_err, m_cerr);
`endif
        cmp_writes(tag);
    endtask

    task automatic full_load(input string tag, input bit pattern);
        logic [7:0] d;
        logic [7:0] s;
        s = 8'h00;
        req();
        chk({tag, " busy_on"}, busy, 1);
        chk({tag, " hold_on"}, cpu_hold, 1);
        for (int i = 0; i < N; i++) begin
            d = pattern ? 8'(8'h10 + i) : 8'($urandom);
            s = s + d;
            strobe_byte(d, 3 + int'($urandom_range(0, 2)));
        end
`ifdef LOADER_CHECKSUM_EN
        strobe_byte(8'(0 - s), 3);
`endif
        end_session(tag);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " addr"}, ram_addr, 0);
        chk({tag, " data"}, ram_data, 0);
        chk({tag, " we"}, ram_we, 0);
        chk({tag, " hold"}, cpu_hold, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " count"}, byte_count, 0);
`ifdef LOADER_CHECKSUM_EN
        chk({tag, " csum_err"}, csum_err, 0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst       = 1'b1;
        load_req  = 1'b0;
        load_end  = 1'b0;
        wr_strobe = 1'b0;
        data_in   = 8'h00;
        cyc(3);
        rst = 1'b0;
        cyc(1);
        chk_reset_vals("reset");

        // Strobes in IDLE are ignored
        strobe_byte(8'h77, 3);
        strobe_byte(8'h88, 3);
        chk("idle busy", busy, 0);
        chk("idle count", byte_count, 0);
        cmp_writes("idle");

        // Full load 0x10..0x1F
        full_load("full_pat", 1);

        // Extra strobe after a full load is ignored
        strobe_byte(8'h5A, 3);
        cyc(2);
        chk("after_full count", byte_count, N);
        chk("after_full done", done, 1);
        cmp_writes("after_full");

        // Strobe held high for 20 cycles writes one byte
        req();
        strobe_byte(8'hA5, 20);
        end_only();
        end_session("held");

        // Five bytes, then load_end with a sixth strobe edge
        req();
        for (int i = 0; i < 5; i++) strobe_byte(8'($urandom), 3);
        data_in   = 8'hEE;
        wr_strobe = 1'b1;
        load_end  = 1'b1;
        cyc(3);
        wr_strobe = 1'b0;
        load_end  = 1'b0;
        cyc(3);
        m_end();
        end_session("end_race");

        // Randomized early-ended and full sessions
        for (int r = 0; r < 3; r++) begin
            n = int'($urandom_range(1, N - 1));
            req();
            for (int i = 0; i < n; i++) strobe_byte(8'($urandom), 3);
            end_only();
            end_session("rand_short");
            full_load("rand_full", 0);
        end

        // Reset in the cycle before the write strobe would fire
        req();
        data_in   = 8'h3C;
        wr_strobe = 1'b1;
        cyc(2);
        rst = 1'b1;
        cyc(1);
        chk_reset_vals("mid_rst");
        m_active = 0;
        m_check  = 0;
        m_cerr   = 0;
        m_idx    = 0;
        rst = 1'b0;
        cyc(4);
        wr_strobe = 1'b0;
        cyc(4);
        chk("mid_rst busy", busy, 0);
        cmp_writes("mid_rst");

`ifdef LOADER_CHECKSUM_EN
        // Good and bad check bytes
        req();
        for (int i = 0; i < N; i++) strobe_byte(8'h01, 3);
        strobe_byte(8'hF0, 3);
        end_session("csum_ok");
        chk("csum_ok model", m_cerr, 0);

        req();
        for (int i = 0; i < N; i++) strobe_byte(8'h01, 3);
        strobe_byte(8'hF1, 3);
        end_session("csum_bad");
        chk("csum_bad model", m_cerr, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
